alarm_bank: RTL

Parametrised multi-channel alarm block, successor to the single-alarm timer-compare controller in the digital clock. It holds `NUM_ALARMS` independently programmable alarms and compares each against the running time of day. Each alarm has its own ring/snooze/stop state machine, with optional daily repeat. It sits beside the time-update datapath, consumes its current hour/minute/second and 1 Hz tick, and drives the buzzer/alarm indicator (`ring`).

---
 rtl/alarm_pkg.sv | 42 ++++
 rtl/alarm_bank_if.sv | 40 ++++
 rtl/alarm_channel.sv | 101 ++++++++++
 rtl/alarm_bank.sv | 72 +++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types, time-field widths and the minute-add helper for the alarm bank.
package alarm_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } alarm_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } hm_t;

  localparam logic [MIN_W:0]    MIN_LIMIT    = (MIN_W+1)'(MAX_MIN);
  localparam logic [MIN_W:0]    MINS_PER_HR  = (MIN_W+1)'(MAX_MIN + 1);
  localparam logic [HOUR_W-1:0] HOUR_LIMIT   = HOUR_W'(MAX_HOUR);

  // delta is at most 59, so at most one carry into the hour is possible.
  function automatic hm_t add_minutes(input logic [HOUR_W-1:0] hour,
                                      input logic [MIN_W-1:0]  min,
                                      input logic [MIN_W-1:0]  delta);
    hm_t            res;
    logic [MIN_W:0] sum;
    sum = {1'b0, min} + {1'b0, delta};
    if (sum > MIN_LIMIT) begin
      res.min  = MIN_W'(sum - MINS_PER_HR);
      res.hour = (hour == HOUR_LIMIT) ? '0 : hour + HOUR_W'(1);
    end else begin
      res.min  = sum[MIN_W-1:0];
      res.hour = hour;
    end
    return res;
  endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Time-of-day, programming and ring-status signals between the clock core and the alarm bank.
interface alarm_bank_if #(
  parameter int NUM_ALARMS = 4
);
  import alarm_pkg::*;

  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  tick_1hz;
  logic [HOUR_W-1:0]     cur_hour;
  logic [MIN_W-1:0]      cur_min;
  logic [MIN_W-1:0]      cur_sec;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [HOUR_W-1:0]     wr_hour;
  logic [MIN_W-1:0]      wr_min;
  logic                  wr_arm;
  logic                  wr_repeat;
  logic                  stop;
  logic                  snooze;
  logic                  wr_err;
  logic                  ring;
  logic [IDX_W-1:0]      ring_idx;
  logic [NUM_ALARMS-1:0] armed;

  modport master (
    output tick_1hz, cur_hour, cur_min, cur_sec,
    output wr_en, wr_idx, wr_hour, wr_min, wr_arm, wr_repeat,
    output stop, snooze,
    input  wr_err, ring, ring_idx, armed
  );

  modport slave (
    input  tick_1hz, cur_hour, cur_min, cur_sec,
    input  wr_en, wr_idx, wr_hour, wr_min, wr_arm, wr_repeat,
    input  stop, snooze,
    output wr_err, ring, ring_idx, armed
  );

endinterface

// File: rtl/alarm_channel.sv
// One alarm: stored time, repeat flag, snooze target, ring counter and its ring/snooze/stop FSM.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic [HOUR_W-1:0] cur_hour_i,
  input  logic [MIN_W-1:0]  cur_min_i,
  input  logic [MIN_W-1:0]  cur_sec_i,
  input  logic              wr_load_i,
  input  logic [HOUR_W-1:0] wr_hour_i,
  input  logic [MIN_W-1:0]  wr_min_i,
  input  logic              wr_arm_i,
  input  logic              wr_repeat_i,
  input  logic              stop_i,
  input  logic              snooze_i,
  output logic              ring_o,
  output logic              armed_o
);

  localparam int                 CNT_W        = $clog2(RING_SECS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(RING_SECS - 1);
  localparam logic [MIN_W-1:0]   SNOOZE_DELTA = MIN_W'(SNOOZE_MIN);

  alarm_state_e      state_q;
  logic [HOUR_W-1:0] hour_q;
  logic [MIN_W-1:0]  min_q;
  logic              repeat_q;
  logic [HOUR_W-1:0] snz_hour_q;
  logic [MIN_W-1:0]  snz_min_q;
  logic [CNT_W-1:0]  cnt_q;

  hm_t               snooze_target_d;
  logic [HOUR_W-1:0] target_hour;
  logic [MIN_W-1:0]  target_min;
  logic              match;

  assign snooze_target_d = add_minutes(cur_hour_i, cur_min_i, SNOOZE_DELTA);

  assign target_hour = (state_q == ST_SNOOZED) ? snz_hour_q : hour_q;
  assign target_min  = (state_q == ST_SNOOZED) ? snz_min_q  : min_q;
  assign match = tick_i && (cur_sec_i == '0) &&
                 (cur_hour_i == target_hour) && (cur_min_i == target_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DISARMED;
      hour_q     <= '0;
      min_q      <= '0;
      repeat_q   <= 1'b0;
      snz_hour_q <= '0;
      snz_min_q  <= '0;
      cnt_q      <= '0;
    end else if (wr_load_i) begin
      hour_q     <= wr_hour_i;
      min_q      <= wr_min_i;
      repeat_q   <= wr_repeat_i;
      snz_hour_q <= '0;
      snz_min_q  <= '0;
      cnt_q      <= '0;
      state_q    <= wr_arm_i ? ST_ARMED : ST_DISARMED;
    end else begin
      unique case (state_q)
        ST_RINGING: begin
          if (stop_i) begin
            state_q <= repeat_q ? ST_ARMED : ST_DISARMED;
            cnt_q   <= '0;
          end else if (snooze_i) begin
            snz_hour_q <= snooze_target_d.hour;
            snz_min_q  <= snooze_target_d.min;
            cnt_q      <= '0;
            state_q    <= ST_SNOOZED;
          end else if (tick_i) begin
            // The match tick itself is not counted; this is the final counted tick.
            if (cnt_q == CNT_LAST) begin
              state_q <= repeat_q ? ST_ARMED : ST_DISARMED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ARMED, ST_SNOOZED: begin
          if (match) begin
            state_q <= ST_RINGING;
            cnt_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ring_o  = (state_q == ST_RINGING);
  assign armed_o = (state_q != ST_DISARMED);

endmodule

// File: rtl/alarm_bank.sv
// Bank of independently programmable alarms; decodes writes and merges per-channel ring status.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  alarm_bank_if.slave bus
);

  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  wr_valid;
  logic                  wr_err_q;
  logic [NUM_ALARMS-1:0] ring_vec;
  logic [NUM_ALARMS-1:0] armed_vec;
  logic [IDX_W-1:0]      ring_idx;

  assign wr_valid = (bus.wr_hour <= HOUR_LIMIT) && (bus.wr_min <= MIN_W'(MAX_MIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_valid;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_chan
      alarm_channel #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_MIN (SNOOZE_MIN)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (bus.tick_1hz),
        .cur_hour_i  (bus.cur_hour),
        .cur_min_i   (bus.cur_min),
        .cur_sec_i   (bus.cur_sec),
        .wr_load_i   (bus.wr_en && wr_valid && (bus.wr_idx == IDX_W'(gi))),
        .wr_hour_i   (bus.wr_hour),
        .wr_min_i    (bus.wr_min),
        .wr_arm_i    (bus.wr_arm),
        .wr_repeat_i (bus.wr_repeat),
        .stop_i      (bus.stop),
        .snooze_i    (bus.snooze),
        .ring_o      (ring_vec[gi]),
        .armed_o     (armed_vec[gi])
      );
    end
  endgenerate

  // Scan high to low so the lowest ringing index wins.
  always_comb begin
    ring_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring_vec[i]) begin
        ring_idx = IDX_W'(i);
      end
    end
  end

  assign bus.wr_err   = wr_err_q;
  assign bus.ring     = |ring_vec;
  assign bus.ring_idx = ring_idx;
  assign bus.armed    = armed_vec;

endmodule
